// File: rtl/packet_receiver_if.sv
// packet_receiver_if: flit handshake between the switch local port and the receiver
interface packet_receiver_if #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 4
);
   localparam int FLIT_SIZE = DATA_SIZE + ADDR_SIZE + 1;
   logic [FLIT_SIZE-1:0] data_i;
   logic                 wr_ready_in;
   logic                 r_ready_out;
   modport master (output data_i, output wr_ready_in, input r_ready_out);
   modport slave  (input data_i, input wr_ready_in, output r_ready_out);
endinterface

// File: rtl/packet_receiver.sv
// packet_receiver: reassembles switch flits into packets, checks address/length, keeps counts
module packet_receiver #(
   parameter int DATA_SIZE      = 8,
   parameter int ADDR_SIZE      = 4,
   parameter int ADDR           = 0,
   parameter int MAX_PACK_LEN   = 8,
   parameter int READ_DELAY     = 0,
   parameter int EXPECTED_PACKS = 0,
   localparam int FLIT_SIZE     = DATA_SIZE + ADDR_SIZE + 1,
   localparam int LEN_W         = $clog2(MAX_PACK_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 a_rst,
   packet_receiver_if.slave     bus,
   output logic [31:0]          recv_packs,
   output logic [31:0]          recv_flits,
   output logic [15:0]          err_cnt,
   output logic                 err_flag,
   output logic [LEN_W-1:0]     last_len,
   output logic [DATA_SIZE-1:0] last_data,
   output logic                 pkt_done,
   output logic                 all_recv
);
   typedef enum logic [1:0] {IDLE, BODY, HOLD} state_t;
   localparam logic [7:0] DLY_M1  = 8'(READ_DELAY - 1);
   localparam bit         HAS_DLY = READ_DELAY != 0;
   state_t                 r_state, w_next;
   logic                   r_ready;
   logic [7:0]             r_dly;
   logic [LEN_W-1:0]       r_cnt, w_cnt1;
   logic [ADDR_SIZE-1:0]   r_cur_addr, w_addr;
   logic                   r_perr, r_serr;
   logic [31:0]            r_recv_packs, r_recv_flits;
   logic [15:0]            r_err_cnt;
   logic                   r_err_flag, r_pkt_done;
   logic [LEN_W-1:0]       r_last_len;
   logic [DATA_SIZE-1:0]   r_last_data, w_data;
   logic                   w_tail, w_acc, w_head, w_aerr, w_serr, w_lerr, w_close, w_bad;
   logic [1:0]             w_nerr;
   logic [16:0]            w_err_sum;
   // Decode the flit, classify its errors and pick the next FSM state
   always_comb begin
      w_tail    = bus.data_i[FLIT_SIZE-1];
      w_addr    = bus.data_i[DATA_SIZE +: ADDR_SIZE];
      w_data    = bus.data_i[DATA_SIZE-1:0];
      w_acc     = bus.wr_ready_in && r_ready;
      w_head    = r_state == IDLE;
      w_cnt1    = w_head ? LEN_W'(1) : r_cnt + LEN_W'(1);
      w_aerr    = w_head && (w_addr != ADDR_SIZE'(ADDR));
      w_serr    = !w_head && !r_serr && (w_addr != r_cur_addr);
      w_lerr    = !w_tail && (w_cnt1 == LEN_W'(MAX_PACK_LEN));
      w_close   = w_tail || w_lerr;
      w_bad     = (!w_head && r_perr) || w_aerr || w_serr || w_lerr;
      w_nerr    = 2'(w_aerr) + 2'(w_serr) + 2'(w_lerr);
      w_err_sum = {1'b0, r_err_cnt} + 17'(w_nerr);
      w_next    = r_state;
      if (r_state == HOLD)
         w_next = (r_dly == 8'd0) ? ((r_cnt != '0) ? BODY : IDLE) : HOLD;
      else if (w_acc)
         w_next = HAS_DLY ? HOLD : (w_close ? IDLE : BODY);
   end
   // FSM state register
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end
   // Registered ready and throttle down-counter; ready drops on the accepting edge
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         r_ready <= 1'b0;
         r_dly   <= 8'd0;
      end else begin
         r_ready <= w_next != HOLD;
         r_dly   <= w_acc ? DLY_M1 : (r_state == HOLD ? r_dly - 8'd1 : r_dly);
      end
   end
   // Packet bookkeeping and statistics, all updated on the accepting edge
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         r_cnt        <= '0;
         r_cur_addr   <= '0;
         r_perr       <= 1'b0;
         r_serr       <= 1'b0;
         r_recv_packs <= '0;
         r_recv_flits <= '0;
         r_err_cnt    <= '0;
         r_err_flag   <= 1'b0;
         r_last_len   <= '0;
         r_last_data  <= '0;
         r_pkt_done   <= 1'b0;
      end else begin
         r_pkt_done <= 1'b0;
         if (w_acc) begin
            r_recv_flits <= r_recv_flits + 32'd1;
            r_last_data  <= w_data;
            r_cur_addr   <= w_head ? w_addr : r_cur_addr;
            r_cnt        <= w_close ? '0 : w_cnt1;
            r_perr       <= !w_close && w_bad;
            r_serr       <= !w_close && (w_serr || (!w_head && r_serr));
            r_err_cnt    <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
            r_err_flag   <= r_err_flag || (w_nerr != 2'd0);
            if (w_close) begin
               r_last_len   <= w_cnt1;
               r_pkt_done   <= 1'b1;
               r_recv_packs <= r_recv_packs + 32'(!w_bad);
            end
         end
      end
   end
   assign bus.r_ready_out = r_ready;
   assign recv_packs      = r_recv_packs;
   assign recv_flits      = r_recv_flits;
   assign err_cnt         = r_err_cnt;
   assign err_flag        = r_err_flag;
   assign last_len        = r_last_len;
   assign last_data       = r_last_data;
   assign pkt_done        = r_pkt_done;
   assign all_recv        = (EXPECTED_PACKS != 0) && (r_recv_packs >= 32'(EXPECTED_PACKS));
endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver: table vectors, corner sequences and a randomized reference-model run on two receivers
module tb_packet_receiver;
   localparam int DS = 8, AS = 4, FS = 13, LW = 3, MAXL = 4, ADR = 3, EXP = 3, D1 = 2, NV = 22;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic          wr = 1'b0;
   logic [FS-1:0] din = '0;
   packet_receiver_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) bus0 ();
   packet_receiver_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) bus1 ();
   assign bus0.data_i = din;
   assign bus0.wr_ready_in = wr;
   assign bus1.data_i = din;
   assign bus1.wr_ready_in = wr;
   logic [31:0]   packs[2], flits[2];
   logic [15:0]   errc[2];
   logic [LW-1:0] llen[2];
   logic [DS-1:0] ldata[2];
   logic          eflag[2], done[2], allr[2], rdy[2];
   assign rdy[0] = bus0.r_ready_out;
   assign rdy[1] = bus1.r_ready_out;
   packet_receiver #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .ADDR(ADR), .MAX_PACK_LEN(MAXL),
      .READ_DELAY(0), .EXPECTED_PACKS(EXP)) u0 (
      .clk(clk), .a_rst(rst), .bus(bus0), .recv_packs(packs[0]), .recv_flits(flits[0]),
      .err_cnt(errc[0]), .err_flag(eflag[0]), .last_len(llen[0]), .last_data(ldata[0]),
      .pkt_done(done[0]), .all_recv(allr[0]));
   packet_receiver #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .ADDR(ADR), .MAX_PACK_LEN(MAXL),
      .READ_DELAY(D1), .EXPECTED_PACKS(EXP)) u1 (
      .clk(clk), .a_rst(rst), .bus(bus1), .recv_packs(packs[1]), .recv_flits(flits[1]),
      .err_cnt(errc[1]), .err_flag(eflag[1]), .last_len(llen[1]), .last_data(ldata[1]),
      .pkt_done(done[1]), .all_recv(allr[1]));
   int n_chk = 0, n_err = 0;
   task automatic check(string name, logic [94:0] act, logic [94:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [94:0] dut_vec(int k);
      return {packs[k], flits[k], errc[k], eflag[k], llen[k], ldata[k], done[k], rdy[k], allr[k]};
   endfunction
   // reference model: acceptance from "N idle cycles after each accept", packet rules in plain arithmetic
   logic          s_rst = 1'b1, s_wr = 1'b0;
   logic [FS-1:0] s_din = '0;
   always @(posedge clk) begin
      s_rst <= rst;
      s_wr  <= wr;
      s_din <= din;
   end
   logic [31:0] m_packs[2], m_flits[2];
   int          m_errc[2], m_cnt[2], m_llen[2], m_hold[2];
   logic [3:0]  m_cur[2];
   logic [7:0]  m_ldata[2];
   logic        m_flag[2], m_done[2], m_ready[2], m_in[2], m_bad[2], m_sw[2];
   logic        chk_en = 1'b0;
   function automatic logic [94:0] m_vec(int k);
      return {m_packs[k], m_flits[k], 16'(m_errc[k]), m_flag[k], LW'(m_llen[k]), m_ldata[k],
              m_done[k], m_ready[k], (EXP != 0) && (m_packs[k] >= EXP)};
   endfunction
   task automatic model_step();
      logic acc, tl;
      logic [3:0] a;
      int ne, d;
      for (int k = 0; k < 2; k++) begin
         d = (k == 0) ? 0 : D1;
         if (s_rst) begin
            m_packs[k] = 0; m_flits[k] = 0; m_errc[k] = 0; m_cnt[k] = 0; m_llen[k] = 0;
            m_hold[k] = 0; m_cur[k] = 0; m_ldata[k] = 0; m_flag[k] = 0; m_done[k] = 0;
            m_ready[k] = 0; m_in[k] = 0; m_bad[k] = 0; m_sw[k] = 0;
         end else begin
            acc = s_wr && m_ready[k];
            m_done[k] = 0;
            if (acc) begin
               tl = s_din[FS-1];
               a  = s_din[DS +: AS];
               ne = 0;
               m_flits[k] = m_flits[k] + 1;
               m_ldata[k] = s_din[DS-1:0];
               if (!m_in[k]) begin
                  m_cnt[k] = 1; m_cur[k] = a; m_bad[k] = 0; m_sw[k] = 0;
                  if (a != ADR) begin ne++; m_bad[k] = 1; end
               end else begin
                  m_cnt[k]++;
                  if (a != m_cur[k]) begin
                     if (!m_sw[k]) ne++;
                     m_sw[k] = 1; m_bad[k] = 1;
                  end
               end
               if (!tl && m_cnt[k] == MAXL) begin ne++; m_bad[k] = 1; end
               m_errc[k] = (m_errc[k] + ne > 65535) ? 65535 : m_errc[k] + ne;
               if (ne > 0) m_flag[k] = 1;
               if (tl || m_cnt[k] == MAXL) begin
                  m_llen[k] = m_cnt[k]; m_done[k] = 1; m_in[k] = 0;
                  if (!m_bad[k]) m_packs[k] = m_packs[k] + 1;
               end else m_in[k] = 1;
            end
            if (acc && d > 0) begin m_ready[k] = 0; m_hold[k] = d; end
            else if (m_hold[k] > 0) begin m_hold[k]--; m_ready[k] = (m_hold[k] == 0); end
            else m_ready[k] = 1;
         end
      end
   endtask
   initial forever begin
      @(negedge clk);
      model_step();
      if (chk_en) begin
         check("model_rd0", dut_vec(0), m_vec(0));
         check("model_rd2", dut_vec(1), m_vec(1));
      end
   end
   typedef struct {
      logic tl; logic [3:0] a; logic [7:0] d;
      logic [31:0] packs, flits; logic [15:0] err; logic flag; logic [2:0] len; logic done; logic all;
   } vec_t;
   vec_t tv[NV];
   function automatic vec_t mk(bit tl, int a, int d, int p, int f, int e, bit fl, int ln, bit dn);
      vec_t v;
      v.tl = tl; v.a = 4'(a); v.d = 8'(d); v.packs = 32'(p); v.flits = 32'(f);
      v.err = 16'(e); v.flag = fl; v.len = 3'(ln); v.done = dn; v.all = p >= EXP;
      return v;
   endfunction
   task automatic check_tv(int i);
      check($sformatf("vec%0d", i),
            95'({packs[0], flits[0], errc[0], eflag[0], llen[0], ldata[0], done[0], allr[0]}),
            95'({tv[i].packs, tv[i].flits, tv[i].err, tv[i].flag, tv[i].len, tv[i].d, tv[i].done, tv[i].all}));
   endtask
   task automatic do_reset();
      wr = 1'b0;
      #1 chk_en = 1'b0;
      rst = 1'b1;
      #1 check("rst_zero0", dut_vec(0), '0);
      check("rst_zero1", dut_vec(1), '0);
      @(negedge clk);
      #1 rst = 1'b0;
      #1 check("rdy_low_after_rel", {rdy[0], rdy[1]}, 2'b00);
      @(posedge clk);
      #1 check("rdy_high_one_edge", {rdy[0], rdy[1]}, 2'b11);
      chk_en = 1'b1;
   endtask
   initial begin
      logic [6:0] pat;
      for (int i = 0; i < 12; i++)
         tv[i] = mk(i % 4 == 3, ADR, i + 16, (i + 1) / 4, i + 1, 0, 0, i >= 3 ? 4 : 0, i % 4 == 3);
      tv[12] = mk(1, ADR, 8'hA5, 4, 13, 0, 0, 1, 1);
      tv[13] = mk(0, 5, 8'h11, 4, 14, 1, 1, 1, 0);
      tv[14] = mk(1, 5, 8'h22, 4, 15, 1, 1, 2, 1);
      for (int i = 0; i < 4; i++)
         tv[15+i] = mk(0, ADR, 8'h40 + i, 4, 16 + i, i == 3 ? 2 : 1, 1, i == 3 ? 4 : 2, i == 3);
      tv[19] = mk(0, ADR, 8'h50, 4, 20, 2, 1, 4, 0);
      tv[20] = mk(0, ADR, 8'h51, 4, 21, 2, 1, 4, 0);
      tv[21] = mk(1, ADR, 8'h52, 5, 22, 2, 1, 3, 1);
      @(negedge clk);
      do_reset();
      pat = 7'b1001001;
      din = {1'b1, 4'(ADR), 8'h77};
      @(negedge clk);
      check("rd_pat0", 95'(rdy[1]), 95'(pat[6]));
      wr = 1'b1;
      for (int j = 1; j < 7; j++) begin
         @(negedge clk);
         check($sformatf("rd_pat%0d", j), 95'(rdy[1]), 95'(pat[6-j]));
      end
      @(negedge clk);
      wr = 1'b0;
      check("rd_flits", {flits[0], flits[1]}, {32'd7, 32'd3});
      @(negedge clk);
      do_reset();
      for (int i = 0; i <= NV; i++) begin
         @(negedge clk);
         if (i > 0) check_tv(i - 1);
         if (i < NV) begin
            din = {tv[i].tl, tv[i].a, tv[i].d};
            wr = 1'b1;
         end else wr = 1'b0;
      end
      @(negedge clk);
      din = {1'b0, 4'(ADR), 8'h01};
      wr = 1'b1;
      @(negedge clk);
      din = {1'b0, 4'(ADR), 8'h02};
      @(negedge clk);
      do_reset();
      @(negedge clk);
      din = {1'b0, 4'(ADR), 8'h31};
      wr = 1'b1;
      @(negedge clk);
      din = {1'b1, 4'(ADR), 8'h32};
      @(negedge clk);
      wr = 1'b0;
      check("post_rst_pkt", {packs[0], 29'd0, llen[0], flits[0], 16'(errc[0])},
            {32'd1, 29'd0, 3'd2, 32'd2, 16'd0});
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         wr  = $urandom_range(0, 3) != 0;
         din = {$urandom_range(0, 2) == 0, ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(ADR),
                8'($urandom)};
      end
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
